// File: rtl/uart_rx_frame_ctrl_pkg.sv
// Shared definitions for the UART receive frame controller.
//   - FSM state encoding (3 bits, HUNT..DRAIN)
//   - Error codes reported on o_Err_Code
//   - Default SYNC_BYTE / CLKS_PER_BIT shared with the UART RX/TX blocks
package uart_rx_frame_ctrl_pkg;

    localparam int unsigned DEFAULT_CLKS_PER_BIT = 217;
    localparam logic [7:0]  DEFAULT_SYNC_BYTE    = 8'hA5;

    typedef enum logic [2:0] {
        StHunt    = 3'd0,
        StLen     = 3'd1,
        StPayload = 3'd2,
        StCsum    = 3'd3,
        StDrain   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        ErrNone    = 2'd0,
        ErrLenBad  = 2'd1,
        ErrCsum    = 2'd2,
        ErrTimeout = 2'd3
    } err_code_t;

endpackage

// File: rtl/uart_frame_buf.sv
// Single-frame payload buffer: DEPTH x 8 register array.
//   clk      in  system clock
//   i_we     in  write enable (synchronous write)
//   i_waddr  in  write address
//   i_wdata  in  write data
//   i_raddr  in  read address (combinational read)
//   o_rdata  out read data
// Contents are not reset; the controller never reads an entry it has not written.
module uart_frame_buf #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [7:0]    o_rdata
);

    logic [7:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Frame controller behind the UART receiver. Hunts for SYNC_BYTE, parses length,
// payload and checksum with an inter-byte timeout, buffers one frame and releases
// the payload over valid/ready only once the checksum verifies.
//   clk, rst_n                 clock, asynchronous active-low reset
//   i_RX_DV, i_RX_Byte         byte stream from the UART receiver
//   o_Pay_Valid/Byte/Last      payload stream, i_Pay_Ready accepts
//   o_Len                      length of the last good frame
//   o_Frame_Done, o_Frame_Err  one-cycle outcome pulses; o_Err_Code holds the reason
//   o_Drop                     pulse: byte arrived during DRAIN and was discarded
//   o_Busy                     high whenever not hunting for a sync byte
module uart_rx_frame_ctrl
    import uart_rx_frame_ctrl_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned TIMEOUT_BITS = 40,
    parameter int unsigned MAX_PAYLOAD  = 16,
    parameter logic [7:0]  SYNC_BYTE    = DEFAULT_SYNC_BYTE
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_RX_DV,
    input  logic [7:0] i_RX_Byte,
    output logic       o_Pay_Valid,
    output logic [7:0] o_Pay_Byte,
    output logic       o_Pay_Last,
    input  logic       i_Pay_Ready,
    output logic [7:0] o_Len,
    output logic       o_Frame_Done,
    output logic       o_Frame_Err,
    output logic [1:0] o_Err_Code,
    output logic       o_Drop,
    output logic       o_Busy
);

    localparam int unsigned     LIMIT    = CLKS_PER_BIT * TIMEOUT_BITS;
    localparam int unsigned     CNT_W    = $clog2(LIMIT) + 1;
    localparam int unsigned     AW       = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
    localparam logic [7:0]      MAX_LEN  = 8'(MAX_PAYLOAD);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LIMIT - 1);

    state_t           r_state;
    err_code_t        r_err_code;
    logic [7:0]       r_len;
    logic [7:0]       r_len_out;
    logic [7:0]       r_sum;
    logic [7:0]       r_wr_ptr;
    logic [7:0]       r_rd_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic             r_frame_done;
    logic             r_frame_err;
    logic             r_drop;

    logic             w_valid;
    logic             w_last;
    logic             w_hs;
    logic             w_we;
    logic             w_timed;
    logic [7:0]       w_csum_sum;
    logic [7:0]       w_rdata;

    assign w_valid    = (r_state == StDrain);
    assign w_last     = w_valid && (r_rd_ptr == r_len - 8'd1);
    assign w_hs       = w_valid && i_Pay_Ready;
    assign w_we       = (r_state == StPayload) && i_RX_DV;
    assign w_timed    = (r_state == StLen) || (r_state == StPayload) || (r_state == StCsum);
    assign w_csum_sum = r_sum + i_RX_Byte;

    uart_frame_buf #(
        .DEPTH (MAX_PAYLOAD),
        .AW    (AW)
    ) u_buf (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr[AW-1:0]),
        .i_wdata (i_RX_Byte),
        .i_raddr (r_rd_ptr[AW-1:0]),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StHunt;
            r_err_code   <= ErrNone;
            r_len        <= '0;
            r_len_out    <= '0;
            r_sum        <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_cnt        <= '0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
            r_drop       <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
            r_drop       <= 1'b0;

            // Inter-byte timeout; an arriving byte always beats an expiring count.
            if (w_timed) begin
                if (i_RX_DV) begin
                    r_cnt <= '0;
                end else if (r_cnt == CNT_LAST) begin
                    r_frame_err <= 1'b1;
                    r_err_code  <= ErrTimeout;
                    r_state     <= StHunt;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else begin
                r_cnt <= '0;
            end

            if (i_RX_DV) begin
                case (r_state)
                    StHunt: begin
                        if (i_RX_Byte == SYNC_BYTE) begin
                            r_state <= StLen;
                        end
                    end
                    StLen: begin
                        if ((i_RX_Byte == 8'd0) || (i_RX_Byte > MAX_LEN)) begin
                            r_frame_err <= 1'b1;
                            r_err_code  <= ErrLenBad;
                            r_state     <= StHunt;
                        end else begin
                            r_len    <= i_RX_Byte;
                            r_sum    <= i_RX_Byte;
                            r_wr_ptr <= '0;
                            r_state  <= StPayload;
                        end
                    end
                    StPayload: begin
                        r_sum    <= w_csum_sum;
                        r_wr_ptr <= r_wr_ptr + 8'd1;
                        if (r_wr_ptr == r_len - 8'd1) begin
                            r_state <= StCsum;
                        end
                    end
                    StCsum: begin
                        if (w_csum_sum == 8'd0) begin
                            r_frame_done <= 1'b1;
                            r_len_out    <= r_len;
                            r_err_code   <= ErrNone;
                            r_rd_ptr     <= '0;
                            r_state      <= StDrain;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_err_code  <= ErrCsum;
                            r_state     <= StHunt;
                        end
                    end
                    StDrain: begin
                        // Receiver cannot be back-pressured; the byte is lost.
                        r_drop <= 1'b1;
                    end
                    default: begin
                        r_state <= StHunt;
                    end
                endcase
            end

            if (w_hs) begin
                r_rd_ptr <= r_rd_ptr + 8'd1;
                if (w_last) begin
                    r_state <= StHunt;
                end
            end
        end
    end

    // Gate the buffer read so nothing undefined is visible outside DRAIN.
    assign o_Pay_Valid  = w_valid;
    assign o_Pay_Byte   = w_valid ? w_rdata : 8'h00;
    assign o_Pay_Last   = w_last;
    assign o_Len        = r_len_out;
    assign o_Frame_Done = r_frame_done;
    assign o_Frame_Err  = r_frame_err;
    assign o_Err_Code   = r_err_code;
    assign o_Drop       = r_drop;
    assign o_Busy       = (r_state != StHunt);

endmodule
